// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
  localparam logic [31:0] ZERO_INSTR       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  // Words that stop fetch once they have been handed to decode.
  function automatic logic is_halt_word(input logic [31:0] w);
    return (w == EBREAK_INSTR) || (w == ZERO_INSTR);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bus: instr_mem address/data, redirect, IF/ID handshake, status
interface fetch_if;

  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        halted_o;
  logic        fault_o;

  modport master (
    output pc_o,
    input  instr_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  id_ready_i,
    output id_valid_o,
    output id_pc_o,
    output id_instr_o,
    output halted_o,
    output fault_o
  );

  modport slave (
    input  pc_o,
    output instr_i,
    output redirect_i,
    output redirect_pc_i,
    output id_ready_i,
    input  id_valid_o,
    input  id_pc_o,
    input  id_instr_o,
    input  halted_o,
    input  fault_o
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register: pc/instruction payload plus valid bit
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        consume,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Flush beats load beats consume; the payload only changes on load so a
  // flushed or consumed entry keeps showing its last contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      instr <= instr_d;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, halt/fault FSM and IF/ID hand-off (option: FETCH_ALIGN_CHECK_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = 2048
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  fetch_state_e state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic         fault_q, fault_n;
  logic         ld, fl, cons;
  logic         load_ok;
  logic         out_of_range;
  logic         redirect_misaligned;

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign out_of_range = ({1'b0, pc_q} + 33'd3) >= 33'(IMEM_BYTES);
  assign load_ok      = (state_q == FS_RUN) && (!bus.id_valid_o || bus.id_ready_i);

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
`else
  assign redirect_misaligned = 1'b0;
`endif

  // State, PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      fault_q <= fault_n;
    end
  end

  // Next-state / control decode: redirect first, then load, then plain drain.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    fault_n = fault_q;
    ld      = 1'b0;
    fl      = 1'b0;
    cons    = 1'b0;
    if (bus.redirect_i) begin
      fl = 1'b1;
      if (redirect_misaligned) begin
        fault_n = 1'b1;
        state_n = FS_HALT;
      end else begin
        pc_n    = bus.redirect_pc_i & ~32'h3;
        state_n = FS_RUN;
      end
    end else if (load_ok) begin
      if (out_of_range) begin
        // Word is dropped; an entry accepted this cycle still drains.
        fault_n = 1'b1;
        state_n = FS_HALT;
        cons    = 1'b1;
      end else begin
        ld = 1'b1;
        if (is_halt_word(bus.instr_i)) begin
          state_n = FS_HALT;
        end else begin
          pc_n = pc_q + 32'd4;
        end
      end
    end else if (bus.id_valid_o && bus.id_ready_i) begin
      cons = 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .flush   (fl),
    .consume (cons),
    .pc_d    (pc_q),
    .instr_d (bus.instr_i),
    .valid   (bus.id_valid_o),
    .pc      (bus.id_pc_o),
    .instr   (bus.id_instr_o)
  );

  assign bus.pc_o     = pc_q;
  assign bus.halted_o = (state_q == FS_HALT);
  assign bus.fault_o  = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;

  localparam int          IMEM  = 2048;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [512];

  assign bus.instr_i = (bus.pc_o < 32'(IMEM)) ? mem[bus.pc_o[10:2]] : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_idpc, m_idinstr;
  logic        m_valid, m_halt, m_fault;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (longint'(a) < longint'(IMEM)) return mem[a[10:2]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_idpc = 32'h0; m_idinstr = NOP;
    m_halt = 1'b0; m_fault = 1'b0;
  endtask

  // One clock of the fetch rules, evaluated from the inputs presented before the edge.
  task automatic model_step();
    logic [31:0] w;
    logic        accept;
    if (!rst) begin
      model_reset();
      return;
    end
    accept = m_valid && bus.id_ready_i;
    if (bus.redirect_i) begin
      m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc_i % 4 != 0) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
        return;
      end
`endif
      m_pc   = (bus.redirect_pc_i / 4) * 4;
      m_halt = 1'b0;
    end else if (!m_halt && (!m_valid || bus.id_ready_i)) begin
      if (longint'(m_pc) + 3 >= longint'(IMEM)) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
        m_valid = 1'b0;
      end else begin
        w         = rd(m_pc);
        m_idpc    = m_pc;
        m_idinstr = w;
        m_valid   = 1'b1;
        if (w == EBRK || w == 32'h0) m_halt = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     bus.pc_o,             m_pc);
    chk({tag, ".valid"},  32'(bus.id_valid_o),  32'(m_valid));
    chk({tag, ".idpc"},   bus.id_pc_o,          m_idpc);
    chk({tag, ".idinstr"}, bus.id_instr_o,      m_idinstr);
    chk({tag, ".halted"}, 32'(bus.halted_o),    32'(m_halt));
    chk({tag, ".fault"},  32'(bus.fault_o),     32'(m_fault));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [31:0] w;
      w = $urandom | 32'h3;
      if (w == EBRK) w = w ^ 32'h4;
      mem[i] = w;
    end
    mem[8] = EBRK;
    for (int i = 0; i < 4; i++) mem[$urandom_range(100, 500)] = 32'h0;

    rst = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("reset.pc",      bus.pc_o, 32'h0);
    chk("reset.valid",   32'(bus.id_valid_o), 32'h0);
    chk("reset.idpc",    bus.id_pc_o, 32'h0);
    chk("reset.idinstr", bus.id_instr_o, NOP);
    chk("reset.halted",  32'(bus.halted_o), 32'h0);
    chk("reset.fault",   32'(bus.fault_o), 32'h0);

    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("seq");
    chk("seq.pc12", bus.pc_o, 32'hC);
    chk("seq.idpc8", bus.id_pc_o, 32'h8);

    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.pc", bus.pc_o, 32'hC);
    bus.id_ready_i = 1'b1;
    step("release");
    chk("release.idpc", bus.id_pc_o, 32'hC);

    for (int i = 0; i < 8 && m_pc != 32'h10; i++) step("to10");
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
    step("redir");
    chk("redir.pc", bus.pc_o, 32'h40);
    chk("redir.valid", 32'(bus.id_valid_o), 32'h0);
    bus.redirect_i = 1'b0;
    step("redir2");
    chk("redir2.idpc", bus.id_pc_o, 32'h40);

    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h18;
    step("to18");
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 5; i++) step("ebrk");
    chk("ebrk.pc", bus.pc_o, 32'h20);
    chk("ebrk.halted", 32'(bus.halted_o), 32'h1);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0;
    step("resume");
    chk("resume.halted", 32'(bus.halted_o), 32'h0);
    bus.redirect_i = 1'b0;
    step("resume2");

    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h7FE;
    step("edge");
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) step("edge2");
    chk("edge.fault", 32'(bus.fault_o), 32'h1);

    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0;
    step("back");
    bus.redirect_i = 1'b0;
    bus.id_ready_i = 1'b0;
    step("prestall"); step("prestall");
    rst = 1'b0;
    step("midrst");
    chk("midrst.pc", bus.pc_o, 32'h0);
    chk("midrst.fault", 32'(bus.fault_o), 32'h0);
    rst = 1'b1;

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.id_ready_i = ($urandom_range(0, 3) != 0);
      bus.redirect_i = 1'b0;
      rst = (r >= 2);
      if (r >= 2 && r < 12) begin
        bus.redirect_i = 1'b1;
        case ($urandom_range(0, 3))
          0: bus.redirect_pc_i = 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(1, 3));
          1: bus.redirect_pc_i = 32'h7F0 + 32'($urandom_range(0, 3)) * 4;
          2: bus.redirect_pc_i = $urandom;
          default: bus.redirect_pc_i = 32'($urandom_range(0, 511)) * 4;
        endcase
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
